// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types, widths and check helpers for tt_sweep_capture
//
// Purpose: FSM state type, truth-table/index widths, and the popcount and
//          first-set-bit functions used when results are evaluated.
// Ports:   none (package).
package tt_sweep_pkg;

  localparam int TT_W  = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [TT_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < TT_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Lowest set bit index; 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] first_set(input logic [TT_W-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// rtl/tt_sweep_capture_if.sv - start/done handshake and result bus of tt_sweep_capture
//
// Purpose: groups the request (start, expected) and result signals.
// Signals: start, expected[15:0]        master -> slave
//          busy, done, tt[15:0], pass,
//          mismatch_cnt[4:0], first_fail[3:0]  slave -> master
interface tt_sweep_capture_if;
  import tt_sweep_pkg::*;

  logic             start;
  logic [TT_W-1:0]  expected;
  logic             busy;
  logic             done;
  logic [TT_W-1:0]  tt;
  logic             pass;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [IDX_W-1:0] first_fail;

  modport master (
    output start, expected,
    input  busy, done, tt, pass, mismatch_cnt, first_fail
  );

  modport slave (
    input  start, expected,
    output busy, done, tt, pass, mismatch_cnt, first_fail
  );

endinterface

// File: rtl/tt_compare.sv
// rtl/tt_compare.sv - combinational truth-table comparison
//
// Purpose: compares a captured truth table against the expected one.
// Ports:   tt[15:0], expected[15:0]  in
//          pass, mismatch_cnt[4:0], first_fail[3:0]  out (first_fail is 0 on pass)
module tt_compare
  import tt_sweep_pkg::*;
(
  input  logic [TT_W-1:0]  tt,
  input  logic [TT_W-1:0]  expected,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [IDX_W-1:0] first_fail
);

  logic [TT_W-1:0] diff;

  assign diff         = tt ^ expected;
  assign pass         = (diff == '0);
  assign mismatch_cnt = popcount(diff);
  assign first_fail   = first_set(diff);

endmodule

// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - sweeps a 4-input function through all minterms and checks its table
//
// Purpose: drives x0..x3 through minterms 0..15, samples y0 per minterm into tt,
//          then compares tt with the expected table latched at start.
// Params:  SETTLE (0..15) extra wait cycles per minterm before y0 is sampled.
// Ports:   clk, rst (sync, active-high)
//          bus  tt_sweep_capture_if.slave: start/expected in; busy/done/results out
//          x0..x3 out minterm drive (0 outside SWEEP); y0 in function output
// Config:  TT_REG_SAMPLE_EN - register y0 before capture; adds one SWEEP cycle.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  tt_sweep_capture_if.slave bus,
  output logic              x0,
  output logic              x1,
  output logic              x2,
  output logic              x3,
  input  logic              y0
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       wait_cnt;
  logic [TT_W-1:0]  exp_q;
  logic [TT_W-1:0]  tt_q;
  logic             pass_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] ff_q;

  logic             cmp_pass;
  logic [CNT_W-1:0] cmp_cnt;
  logic [IDX_W-1:0] cmp_ff;

  logic             win_end;     // last cycle of the current minterm window
  logic             sweep_last;  // final SWEEP cycle

`ifdef TT_REG_SAMPLE_EN
  logic             y0_q;
  logic             cap_pend;    // y0_q holds a window-end sample to store this cycle
  logic [IDX_W-1:0] cap_idx;
  logic             tail;        // extra cycle after minterm 15 to store its late sample

  assign win_end    = (state == SWEEP) && !tail && (wait_cnt == SETTLE_C);
  assign sweep_last = tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      y0_q     <= 1'b0;
      cap_pend <= 1'b0;
      cap_idx  <= '0;
      tail     <= 1'b0;
    end else begin
      y0_q     <= y0;
      cap_pend <= win_end;
      if (win_end) begin
        cap_idx <= idx;
      end
      if (state == IDLE) begin
        tail <= 1'b0;
      end else if (win_end && (idx == IDX_LAST)) begin
        tail <= 1'b1;
      end
    end
  end
`else
  assign win_end    = (state == SWEEP) && (wait_cnt == SETTLE_C);
  assign sweep_last = win_end && (idx == IDX_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SWEEP;
      SWEEP:   if (sweep_last) state_nxt = CHECK;
      CHECK:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      wait_cnt <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      pass_q   <= 1'b0;
      cnt_q    <= '0;
      ff_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_q    <= bus.expected;
            idx      <= '0;
            wait_cnt <= '0;
            tt_q     <= '0;
            pass_q   <= 1'b0;
          end
        end
        SWEEP: begin
          if (win_end) begin
            wait_cnt <= '0;
            // idx parks at 15 so x stays there through any trailing cycle.
            if (idx != IDX_LAST) begin
              idx <= idx + IDX_W'(1);
            end
`ifndef TT_REG_SAMPLE_EN
            tt_q[idx] <= y0;
`endif
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        CHECK: begin
          pass_q <= cmp_pass;
          cnt_q  <= cmp_cnt;
          ff_q   <= cmp_ff;
        end
        default: ;
      endcase
`ifdef TT_REG_SAMPLE_EN
      if (cap_pend) begin
        tt_q[cap_idx] <= y0_q;
      end
`endif
    end
  end

  tt_compare u_compare (
    .tt           (tt_q),
    .expected     (exp_q),
    .pass         (cmp_pass),
    .mismatch_cnt (cmp_cnt),
    .first_fail   (cmp_ff)
  );

  assign {x3, x2, x1, x0}  = (state == SWEEP) ? idx : '0;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.tt           = tt_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_cnt = cnt_q;
  assign bus.first_fail   = ff_q;

endmodule
